// File: rtl/u111_cycle_ctrl.sv
// U111 68040 local-bus cycle controller: accepts CPU transfer starts and
// terminates them with TAn/TBIn/TEAn. Optional macro: U111_BUS_TIMEOUT_EN.
module u111_cycle_ctrl #(
  parameter int unsigned WAIT_STATES    = 2,
  parameter int unsigned BURST_BEATS    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       CLK40,
  input  logic       RESET,
  input  logic       TSn,
  input  logic       BGn,
  input  logic       RnW,
  input  logic [1:0] SIZ,
  input  logic       ONBOARD,
  input  logic       ACKn,
  output logic       CYCLE_EN,
  output logic       LBENn,
  output logic       TAn,
  output logic       TBIn,
  output logic       TEAn,
  output logic       CYC_RnW
);

  typedef enum logic [2:0] {
    IDLE,
    OWAIT,
    OBEAT,
    XWAIT,
    XACK,
    XERR,
    TERM
  } state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_STATES);
  localparam logic [7:0] BEAT_LD = 8'(BURST_BEATS - 1);

  state_t     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic [7:0] beat_q, beat_d;
  logic       line_q, line_d;
  logic       rnw_q, rnw_d;
  logic       to_hit;

`ifdef U111_BUS_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] tcnt_q, tcnt_d;

  // Timeout counter: zero on XWAIT entry, counts XWAIT clocks, saturates
  always_comb begin
    tcnt_d = tcnt_q;
    if (state_q != XWAIT) begin
      tcnt_d = 8'd0;
    end else if (tcnt_q != 8'hFF) begin
      tcnt_d = tcnt_q + 8'd1;
    end
  end

  // Timeout counter register
  always_ff @(posedge CLK40) begin
    if (RESET) begin
      tcnt_q <= 8'd0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end

  assign to_hit = (tcnt_q == TO_LAST);
`else
  // Legal timeout range excludes zero, so this is constant low:
  // XWAIT waits for ACKn indefinitely.
  assign to_hit = (TIMEOUT_CYCLES == 0);
`endif

  // Next-state logic: accept, wait-state and beat sequencing
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    beat_d  = beat_q;
    line_d  = line_q;
    rnw_d   = rnw_q;
    unique case (state_q)
      IDLE: begin
        if (!TSn && !BGn) begin
          rnw_d   = RnW;
          line_d  = (SIZ == 2'b11);
          wait_d  = WAIT_LD;
          beat_d  = (SIZ == 2'b11) ? BEAT_LD : 8'd0;
          state_d = ONBOARD ? OWAIT : XWAIT;
        end
      end
      OWAIT: begin
        if (wait_q == 4'd0) begin
          state_d = OBEAT;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      OBEAT: begin
        if (beat_q == 8'd0) begin
          state_d = TERM;
        end else begin
          beat_d = beat_q - 8'd1;
        end
      end
      XWAIT: begin
        if (!ACKn) begin
          state_d = XACK;
        end else if (to_hit) begin
          state_d = XERR;
        end
      end
      XACK:    state_d = TERM;
      XERR:    state_d = TERM;
      TERM:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and latched cycle attributes
  always_ff @(posedge CLK40) begin
    if (RESET) begin
      state_q <= IDLE;
      wait_q  <= 4'd0;
      beat_q  <= 8'd0;
      line_q  <= 1'b0;
      rnw_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      rnw_q   <= rnw_d;
    end
  end

  assign CYCLE_EN = (state_q == OWAIT) || (state_q == OBEAT)
                 || (state_q == XWAIT) || (state_q == XACK)
                 || (state_q == XERR);
  assign LBENn    = !((state_q == OWAIT) || (state_q == OBEAT));
  assign TAn      = !((state_q == OBEAT) || (state_q == XACK));
  assign TBIn     = !((state_q == XACK) && line_q);
  assign TEAn     = !(state_q == XERR);
  assign CYC_RnW  = rnw_q;

endmodule

// File: tb/tb_u111_cycle_ctrl.sv
// Self-checking bench for u111_cycle_ctrl: directed scenarios plus
// randomized cycles checked against a per-clock trace model.
module tb_u111_cycle_ctrl;

  localparam int W = 2;
  localparam int B = 4;
  localparam int T = 8;
`ifdef U111_BUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       CLK40 = 1'b0;
  logic       RESET = 1'b1;
  logic       TSn = 1'b1;
  logic       BGn = 1'b0;
  logic       RnW = 1'b1;
  logic [1:0] SIZ = 2'b00;
  logic       ONBOARD = 1'b0;
  logic       ACKn = 1'b1;
  logic       CYCLE_EN, LBENn, TAn, TBIn, TEAn, CYC_RnW;

  int checks = 0;
  int errors = 0;

  u111_cycle_ctrl #(
    .WAIT_STATES(W),
    .BURST_BEATS(B),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .CLK40(CLK40),
    .RESET(RESET),
    .TSn(TSn),
    .BGn(BGn),
    .RnW(RnW),
    .SIZ(SIZ),
    .ONBOARD(ONBOARD),
    .ACKn(ACKn),
    .CYCLE_EN(CYCLE_EN),
    .LBENn(LBENn),
    .TAn(TAn),
    .TBIn(TBIn),
    .TEAn(TEAn),
    .CYC_RnW(CYC_RnW)
  );

  always #5 CLK40 = ~CLK40;

  // {CYCLE_EN, LBENn, TAn, TBIn, TEAn, CYC_RnW}
  function automatic logic [5:0] obs();
    return {CYCLE_EN, LBENn, TAn, TBIn, TEAn, CYC_RnW};
  endfunction

  // Index of the TERM clock, counted from the accept edge (index 0)
  function automatic int term_idx(bit onb, bit line, int d);
    if (onb) return W + (line ? B : 1) + 1;
    if (d >= 1 && (!TO_EN || d <= T)) return d + 1;
    return T + 1;
  endfunction

  // Expected outputs after edge idx of a cycle accepted at edge 0;
  // d = edge index at which ACKn is first sampled low (0 = never).
  function automatic logic [5:0] model(int idx, bit onb, bit line,
                                       bit rnw, int d);
    int  e;
    bit  ack;
    e   = term_idx(onb, line, d);
    ack = (d >= 1) && (!TO_EN || d <= T);
    if (idx >= e) return {5'b01111, rnw};
    if (onb) begin
      if (idx <= W) return {5'b10111, rnw};
      return {5'b10011, rnw};
    end
    if (idx < e - 1) return {5'b11111, rnw};
    if (ack) return {3'b110, !line, 1'b1, rnw};
    return {5'b11110, rnw};
  endfunction

  task automatic run_cycle(input bit onb, input logic [1:0] siz,
                           input bit rnw, input int d, input bit noise,
                           input string name);
    int          e;
    bit          line;
    logic [5:0]  ex;
    line = (siz == 2'b11);
    e    = term_idx(onb, line, d);
    TSn = 1'b0; BGn = 1'b0; ONBOARD = onb; SIZ = siz; RnW = rnw;
    ACKn = 1'b1;
    for (int idx = 0; idx <= e + 1; idx++) begin
      @(posedge CLK40); #1;
      ex = model(idx, onb, line, rnw, d);
      checks++;
      if (obs() !== ex) begin
        errors++;
        $display("FAIL %s idx=%0d got=%b want=%b", name, idx, obs(), ex);
      end
      TSn  = (noise && idx < e + 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (idx == e) TSn = 1'b0;
      if (idx == e + 1) TSn = 1'b1;
      if (noise) begin
        ONBOARD = 1'($urandom_range(0, 1));
        SIZ     = 2'($urandom_range(0, 3));
        RnW     = 1'($urandom_range(0, 1));
      end
      ACKn = (idx + 1 == d) ? 1'b0 : 1'b1;
    end
  endtask

  task automatic expect_idle(input int n, input logic rnw,
                             input string name);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK40); #1;
      checks++;
      if (obs() !== {5'b01111, rnw}) begin
        errors++;
        $display("FAIL %s clk=%0d got=%b want=%b", name, i, obs(),
                 {5'b01111, rnw});
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; BGn = 1'b0; ONBOARD = 1'b1;
    for (int i = 0; i < 2; i++) begin
      TSn = i[0];
      @(posedge CLK40); #1;
      checks++;
      if (obs() !== 6'b011111) begin
        errors++;
        $display("FAIL reset clk=%0d got=%b want=011111", i, obs());
      end
    end
    RESET = 1'b0; TSn = 1'b1;
    expect_idle(2, 1'b1, "reset_idle");
  endtask

  task automatic test_onboard_read();
    run_cycle(1'b1, 2'b00, 1'b1, 0, 1'b0, "onboard_read");
  endtask

  task automatic test_onboard_burst();
    run_cycle(1'b1, 2'b11, 1'b1, 0, 1'b0, "onboard_burst");
  endtask

  task automatic test_offboard_write();
    run_cycle(1'b0, 2'b11, 1'b0, 5, 1'b0, "offboard_write");
    expect_idle(1, 1'b0, "offboard_hold");
  endtask

  task automatic test_grant_gating();
    BGn = 1'b1; TSn = 1'b0; ONBOARD = 1'b1; RnW = 1'b1;
    expect_idle(3, 1'b0, "grant_gate");
    TSn = 1'b1; BGn = 1'b0;
  endtask

  task automatic test_mid_reset();
    TSn = 1'b0; BGn = 1'b0; ONBOARD = 1'b1; SIZ = 2'b00; RnW = 1'b0;
    @(posedge CLK40); #1;
    checks++;
    if (obs() !== 6'b101110) begin
      errors++;
      $display("FAIL mid_reset_accept got=%b want=101110", obs());
    end
    TSn = 1'b1; RESET = 1'b1;
    @(posedge CLK40); #1;
    checks++;
    if (obs() !== 6'b011111) begin
      errors++;
      $display("FAIL mid_reset got=%b want=011111", obs());
    end
    RESET = 1'b0;
    expect_idle(5, 1'b1, "mid_reset_after");
  endtask

  task automatic test_back_to_back();
    run_cycle(1'b1, 2'b01, 1'b0, 0, 1'b0, "b2b_first");
    run_cycle(1'b0, 2'b00, 1'b1, 1, 1'b0, "b2b_second");
  endtask

  task automatic test_timeout();
    run_cycle(1'b0, 2'b10, 1'b1, 0, 1'b0, "timeout");
    run_cycle(1'b0, 2'b11, 1'b1, T, 1'b0, "timeout_ack_wins");
  endtask

  task automatic test_random();
    bit         onb;
    logic [1:0] siz;
    bit         rnw;
    int         d;
    for (int n = 0; n < 40; n++) begin
      onb = 1'($urandom_range(0, 1));
      siz = 2'($urandom_range(0, 3));
      rnw = 1'($urandom_range(0, 1));
      d   = TO_EN ? int'($urandom_range(0, 12))
                  : int'($urandom_range(1, 9));
      run_cycle(onb, siz, rnw, d, 1'b1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_onboard_read();
    test_onboard_burst();
    test_offboard_write();
    test_grant_gating();
    test_mid_reset();
    test_back_to_back();
    if (TO_EN) test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
